move_request_arbiter: RTL

//  Owns the red-square grid position for the VGA game and shares it between two move

---
 rtl/move_request_arbiter_pkg.sv | 52 +++++
 rtl/move_request_arbiter_if.sv | 34 +++
 rtl/move_request_arbiter_slot.sv | 53 +++++
 rtl/move_request_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/move_request_arbiter_pkg.sv
// Shared definitions for the move request arbiter: direction/source codes, FSM codes,
// request payload types and the direction encoder used by both request slots.
package move_request_arbiter_pkg;

    localparam int unsigned POS_W = 3;
    localparam int unsigned DIR_W = 2;
    localparam int unsigned ST_W  = 2;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd1;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd3;

    localparam logic SRC_BTN = 1'b0;
    localparam logic SRC_KBD = 1'b1;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_ARMED = 2'd1;
    localparam logic [ST_W-1:0] ST_APPLY = 2'd2;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_req_t;

    typedef struct packed {
        logic             valid;
        logic [DIR_W-1:0] dir;
    } move_req_t;

    // Opposing directions on one axis cancel, then up > down > left > right.
    function automatic move_req_t encode_dir(input dir_req_t r);
        move_req_t res;
        logic      up_e;
        logic      down_e;
        logic      left_e;
        logic      right_e;
        up_e      = r.up & ~r.down;
        down_e    = r.down & ~r.up;
        left_e    = r.left & ~r.right;
        right_e   = r.right & ~r.left;
        res.valid = up_e | down_e | left_e | right_e;
        if (up_e)        res.dir = DIR_UP;
        else if (down_e) res.dir = DIR_DOWN;
        else if (left_e) res.dir = DIR_LEFT;
        else             res.dir = DIR_RIGHT;
        return res;
    endfunction

endpackage

// File: rtl/move_request_arbiter_if.sv
// Move sources in, grid position and status pulses out.
interface move_request_arbiter_if;
    import move_request_arbiter_pkg::*;

    logic             frame_tick;
    logic             btn_up;
    logic             btn_down;
    logic             btn_left;
    logic             btn_right;
    logic             kbd_valid;
    logic             kbd_up;
    logic             kbd_down;
    logic             kbd_left;
    logic             kbd_right;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic             moved;
    logic             blocked;
    logic             overrun;
    logic             grant_kbd;

    modport master (
        output frame_tick, btn_up, btn_down, btn_left, btn_right,
        output kbd_valid, kbd_up, kbd_down, kbd_left, kbd_right,
        input  pos_x, pos_y, moved, blocked, overrun, grant_kbd
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right,
        input  kbd_valid, kbd_up, kbd_down, kbd_left, kbd_right,
        output pos_x, pos_y, moved, blocked, overrun, grant_kbd
    );

endinterface

// File: rtl/move_request_arbiter_slot.sv
// One-entry pending-move slot for a single source: encodes the request, holds it until
// granted, and flags when an unserviced entry is overwritten.
module move_request_arbiter_slot
    import move_request_arbiter_pkg::*;
(
    input  logic             Clock,
    input  logic             n_reset,
    input  logic             sample,
    input  dir_req_t         dirs,
    input  logic             clear,
    output logic             valid,
    output logic [DIR_W-1:0] dir,
    output logic             overrun_c
);

    logic             valid_q;
    logic             valid_d;
    logic [DIR_W-1:0] dir_q;
    logic [DIR_W-1:0] dir_d;
    move_req_t        req;
    logic             req_fire;

    // Clear-on-grant happens first so a same-cycle request lands in the freed slot.
    always_comb begin
        req       = encode_dir(dirs);
        req_fire  = sample & req.valid;
        valid_d   = valid_q;
        dir_d     = dir_q;
        overrun_c = 1'b0;
        if (clear) begin
            valid_d = 1'b0;
        end
        if (req_fire) begin
            overrun_c = valid_q & ~clear;
            valid_d   = 1'b1;
            dir_d     = req.dir;
        end
    end

    always_ff @(posedge Clock) begin
        if (!n_reset) begin
            valid_q <= 1'b0;
            dir_q   <= DIR_UP;
        end else begin
            valid_q <= valid_d;
            dir_q   <= dir_d;
        end
    end

    assign valid = valid_q;
    assign dir   = dir_q;

endmodule

// File: rtl/move_request_arbiter.sv
// Owns the square's grid position and applies at most one pending move per frame,
// round-robin between the push-button and keyboard sources.
module move_request_arbiter
    import move_request_arbiter_pkg::*;
#(
    parameter int unsigned GRID_N    = 7,
    parameter int unsigned START_POS = 3,
    parameter bit          WRAP      = 1'b0
) (
    input  logic                   Clock,
    input  logic                   n_reset,
    move_request_arbiter_if.slave  bus
);

    localparam logic [POS_W-1:0] MAX_POS   = POS_W'(GRID_N - 1);
    localparam logic [POS_W-1:0] RESET_POS = POS_W'(START_POS);

    logic [ST_W-1:0]  state_q;
    logic [ST_W-1:0]  state_d;
    logic             rr_q;
    logic             rr_d;
    logic [POS_W-1:0] pos_x_q;
    logic [POS_W-1:0] pos_x_d;
    logic [POS_W-1:0] pos_y_q;
    logic [POS_W-1:0] pos_y_d;
    logic             moved_q;
    logic             moved_d;
    logic             blocked_q;
    logic             blocked_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             grant_kbd_q;
    logic             grant_kbd_d;
    dir_req_t         btn_prev_q;

    dir_req_t         btn_lvl;
    dir_req_t         btn_rise;
    dir_req_t         kbd_dirs;
    logic             btn_valid;
    logic [DIR_W-1:0] btn_dir;
    logic             btn_ovr_c;
    logic             kbd_valid;
    logic [DIR_W-1:0] kbd_dir;
    logic             kbd_ovr_c;
    logic             clr_btn;
    logic             clr_kbd;
    logic             gsrc;
    logic [DIR_W-1:0] gdir;
    logic             vert;
    logic             dec;
    logic             at_edge;
    logic [POS_W-1:0] cur;
    logic [POS_W-1:0] nxt;

    assign btn_lvl  = '{up: bus.btn_up, down: bus.btn_down, left: bus.btn_left, right: bus.btn_right};
    assign kbd_dirs = '{up: bus.kbd_up, down: bus.kbd_down, left: bus.kbd_left, right: bus.kbd_right};
    assign btn_rise = dir_req_t'(btn_lvl & ~btn_prev_q);

    move_request_arbiter_slot u_btn_slot (
        .Clock     (Clock),
        .n_reset   (n_reset),
        .sample    (1'b1),
        .dirs      (btn_rise),
        .clear     (clr_btn),
        .valid     (btn_valid),
        .dir       (btn_dir),
        .overrun_c (btn_ovr_c)
    );

    move_request_arbiter_slot u_kbd_slot (
        .Clock     (Clock),
        .n_reset   (n_reset),
        .sample    (bus.kbd_valid),
        .dirs      (kbd_dirs),
        .clear     (clr_kbd),
        .valid     (kbd_valid),
        .dir       (kbd_dir),
        .overrun_c (kbd_ovr_c)
    );

    // Source selection, next position and next state.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        moved_d     = 1'b0;
        blocked_d   = 1'b0;
        overrun_d   = btn_ovr_c | kbd_ovr_c;
        grant_kbd_d = grant_kbd_q;
        clr_btn     = 1'b0;
        clr_kbd     = 1'b0;
        gsrc        = SRC_BTN;
        gdir        = btn_dir;
        vert        = 1'b0;
        dec         = 1'b0;
        at_edge     = 1'b0;
        cur         = pos_x_q;
        nxt         = pos_x_q;

        case (state_q)
            ST_IDLE: begin
                if (btn_valid || kbd_valid) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus.frame_tick) begin
                    state_d = ST_APPLY;
                    if (btn_valid && kbd_valid) begin
                        gsrc = rr_q;
                        rr_d = ~rr_q;
                    end else begin
                        gsrc = kbd_valid ? SRC_KBD : SRC_BTN;
                    end
                    gdir        = (gsrc == SRC_KBD) ? kbd_dir : btn_dir;
                    clr_btn     = (gsrc == SRC_BTN);
                    clr_kbd     = (gsrc == SRC_KBD);
                    grant_kbd_d = gsrc;

                    vert    = (gdir == DIR_UP) || (gdir == DIR_DOWN);
                    dec     = (gdir == DIR_UP) || (gdir == DIR_LEFT);
                    cur     = vert ? pos_y_q : pos_x_q;
                    at_edge = dec ? (cur == '0) : (cur == MAX_POS);
                    if (at_edge) begin
                        nxt = dec ? MAX_POS : '0;
                    end else begin
                        nxt = dec ? POS_W'(cur - POS_W'(1)) : POS_W'(cur + POS_W'(1));
                    end

                    if (at_edge && !WRAP) begin
                        blocked_d = 1'b1;
                    end else begin
                        moved_d = 1'b1;
                        if (vert) pos_y_d = nxt;
                        else      pos_x_d = nxt;
                    end
                end
            end
            ST_APPLY: begin
                if (grant_kbd_q ? btn_valid : kbd_valid) state_d = ST_ARMED;
                else                                     state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Previous button levels track the inputs through reset so a held button is no edge.
    always_ff @(posedge Clock) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            rr_q        <= SRC_BTN;
            pos_x_q     <= RESET_POS;
            pos_y_q     <= RESET_POS;
            moved_q     <= 1'b0;
            blocked_q   <= 1'b0;
            overrun_q   <= 1'b0;
            grant_kbd_q <= SRC_BTN;
            btn_prev_q  <= btn_lvl;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            moved_q     <= moved_d;
            blocked_q   <= blocked_d;
            overrun_q   <= overrun_d;
            grant_kbd_q <= grant_kbd_d;
            btn_prev_q  <= btn_lvl;
        end
    end

    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign bus.moved     = moved_q;
    assign bus.blocked   = blocked_q;
    assign bus.overrun   = overrun_q;
    assign bus.grant_kbd = grant_kbd_q;

endmodule
